// File: rtl/wb_write_arbiter.sv
// ============================================================================
//  Module   : wb_write_arbiter
//  Purpose  : Merges pipeline write-back and queued mul/div results onto the
//             single GRF write port, flagging pending queued writes to decode.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [AW-1:0]            wb_addr,
  input  logic [DW-1:0]            wb_data,
  input  logic [DW-1:0]            wb_pc,
  input  logic                     md_valid,
  output logic                     md_ready,
  input  logic [AW-1:0]            md_addr,
  input  logic [DW-1:0]            md_data,
  input  logic [DW-1:0]            md_pc,
  input  logic [AW-1:0]            A1,
  input  logic [AW-1:0]            A2,
  output logic                     pend_hit1,
  output logic                     pend_hit2,
  output logic                     RegWrite,
  output logic [AW-1:0]            RegAddr,
  output logic [DW-1:0]            RegData,
  output logic [DW-1:0]            PC,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int               c_PW    = $clog2(DEPTH);
  localparam int               c_CW    = c_PW + 1;
  localparam logic [c_CW-1:0]  c_DEPTH = c_CW'(DEPTH);

  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [DW-1:0]    r_pc   [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [c_PW-1:0]  r_head;
  logic [c_PW-1:0]  r_tail;
  logic [c_CW-1:0]  r_count;

  logic w_hs;
  logic w_push;
  logic w_wb_take;
  logic w_pop;
  logic w_hit1;
  logic w_hit2;

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign md_ready  = (r_count != c_DEPTH);
  assign q_count   = r_count;

  assign w_hs      = md_valid & md_ready;
  assign w_push    = w_hs & (md_addr != '0);
  assign w_wb_take = wb_valid & (wb_addr != '0);
  assign w_pop     = ~w_wb_take & (r_count != '0);

  // The output register is not searched: the GRF forwards RegData itself.
  always_comb begin
    w_hit1 = w_hs && (md_addr == A1);
    w_hit2 = w_hs && (md_addr == A2);
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_addr[i] == A1)) w_hit1 = 1'b1;
      if (r_vld[i] && (r_addr[i] == A2)) w_hit2 = 1'b1;
    end
  end

  assign pend_hit1 = (A1 != '0) && w_hit1;
  assign pend_hit2 = (A2 != '0) && w_hit2;

  // Payload storage needs no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= md_addr;
      r_data[r_tail] <= md_data;
      r_pc[r_tail]   <= md_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + 1'b1;
      end
      // Push and pop never target the same slot: pop needs count>0, push
      // needs count<DEPTH, so head==tail cannot hold for both.
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWrite <= 1'b0;
      RegAddr  <= '0;
      RegData  <= '0;
      PC       <= '0;
    end else if (w_wb_take) begin
      RegWrite <= 1'b1;
      RegAddr  <= wb_addr;
      RegData  <= wb_data;
      PC       <= wb_pc;
    end else if (w_pop) begin
      RegWrite <= 1'b1;
      RegAddr  <= r_addr[r_head];
      RegData  <= r_data[r_head];
      PC       <= r_pc[r_head];
    end else begin
      RegWrite <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
// ============================================================================
//  Module   : tb_wb_write_arbiter
//  Purpose  : Directed self-checking bench for wb_write_arbiter.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_write_arbiter;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] wb_pc;
  logic          md_valid;
  logic          md_ready;
  logic [AW-1:0] md_addr;
  logic [DW-1:0] md_data;
  logic [DW-1:0] md_pc;
  logic [AW-1:0] A1;
  logic [AW-1:0] A2;
  logic          pend_hit1;
  logic          pend_hit2;
  logic          RegWrite;
  logic [AW-1:0] RegAddr;
  logic [DW-1:0] RegData;
  logic [DW-1:0] PC;
  logic [2:0]    q_count;

  int total = 0;
  int bad   = 0;

  wb_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
    .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr),
    .md_data(md_data), .md_pc(md_pc),
    .A1(A1), .A2(A2), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .RegWrite(RegWrite), .RegAddr(RegAddr), .RegData(RegData), .PC(PC),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0; wb_pc = '0;
    md_valid = 1'b0; md_addr = '0; md_data = '0; md_pc = '0;
  endtask

  task automatic test_reset();
    idle();
    A1 = '0; A2 = '0;
    reset = 1'b0;
    tick(); tick();
    total += 6;
    if (q_count !== 3'd0)  begin bad++; $display("FAIL rst_count got=%0d exp=0", q_count); end
    if (RegWrite !== 1'b0) begin bad++; $display("FAIL rst_regwrite got=%b exp=0", RegWrite); end
    if (RegAddr !== '0)    begin bad++; $display("FAIL rst_regaddr got=%0d exp=0", RegAddr); end
    if (RegData !== '0)    begin bad++; $display("FAIL rst_regdata got=%h exp=0", RegData); end
    if (PC !== '0)         begin bad++; $display("FAIL rst_pc got=%h exp=0", PC); end
    if (md_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", md_ready); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_wb();
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234; wb_pc = 32'h100;
    tick();
    total += 4;
    if (RegWrite !== 1'b1)   begin bad++; $display("FAIL wb_regwrite got=%b exp=1", RegWrite); end
    if (RegAddr !== 5'd5)    begin bad++; $display("FAIL wb_regaddr got=%0d exp=5", RegAddr); end
    if (RegData !== 32'h1234) begin bad++; $display("FAIL wb_regdata got=%h exp=1234", RegData); end
    if (PC !== 32'h100)      begin bad++; $display("FAIL wb_pc got=%h exp=100", PC); end
    idle();
    tick();
    total += 2;
    if (RegWrite !== 1'b0) begin bad++; $display("FAIL wb_idle_regwrite got=%b exp=0", RegWrite); end
    if (RegAddr !== 5'd5)  begin bad++; $display("FAIL wb_hold_addr got=%0d exp=5", RegAddr); end
  endtask

  task automatic test_md_single();
    md_valid = 1'b1; md_addr = 5'd8; md_data = 32'hDEAD; md_pc = 32'h200;
    A1 = 5'd8; A2 = 5'd9;
    #1;
    total += 2;
    if (pend_hit1 !== 1'b1) begin bad++; $display("FAIL md_hit_inflight got=%b exp=1", pend_hit1); end
    if (pend_hit2 !== 1'b0) begin bad++; $display("FAIL md_nohit2 got=%b exp=0", pend_hit2); end
    tick();
    idle();
    #1;
    total += 3;
    if (q_count !== 3'd1)   begin bad++; $display("FAIL md_count1 got=%0d exp=1", q_count); end
    if (pend_hit1 !== 1'b1) begin bad++; $display("FAIL md_hit_queued got=%b exp=1", pend_hit1); end
    if (RegWrite !== 1'b0)  begin bad++; $display("FAIL md_no_bypass got=%b exp=0", RegWrite); end
    tick();
    total += 6;
    if (RegWrite !== 1'b1)    begin bad++; $display("FAIL md_regwrite got=%b exp=1", RegWrite); end
    if (RegAddr !== 5'd8)     begin bad++; $display("FAIL md_regaddr got=%0d exp=8", RegAddr); end
    if (RegData !== 32'hDEAD) begin bad++; $display("FAIL md_regdata got=%h exp=dead", RegData); end
    if (PC !== 32'h200)       begin bad++; $display("FAIL md_pc got=%h exp=200", PC); end
    if (q_count !== 3'd0)     begin bad++; $display("FAIL md_count0 got=%0d exp=0", q_count); end
    if (pend_hit1 !== 1'b0)   begin bad++; $display("FAIL md_hit_cleared got=%b exp=0", pend_hit1); end
  endtask

  task automatic test_fill();
    A1 = '0; A2 = 5'd12;
    wb_valid = 1'b1; wb_addr = 5'd3;
    for (int i = 0; i < DEPTH; i++) begin
      wb_data = 32'h3000 + i; wb_pc = 32'h300 + i;
      md_valid = 1'b1; md_addr = 5'(10 + i); md_data = 32'hA0 + i; md_pc = 32'h400 + i;
      tick();
    end
    md_valid = 1'b0;
    #1;
    total += 5;
    if (q_count !== 3'd4)   begin bad++; $display("FAIL fill_count got=%0d exp=4", q_count); end
    if (md_ready !== 1'b0)  begin bad++; $display("FAIL fill_ready got=%b exp=0", md_ready); end
    if (RegAddr !== 5'd3)   begin bad++; $display("FAIL fill_wb_addr got=%0d exp=3", RegAddr); end
    if (RegData !== 32'h3003) begin bad++; $display("FAIL fill_wb_data got=%h exp=3003", RegData); end
    if (pend_hit2 !== 1'b1) begin bad++; $display("FAIL fill_hit2 got=%b exp=1", pend_hit2); end
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      total += 4;
      if (RegWrite !== 1'b1) begin bad++; $display("FAIL drain_we[%0d] got=%b exp=1", i, RegWrite); end
      if (RegAddr !== 5'(10 + i)) begin bad++; $display("FAIL drain_addr[%0d] got=%0d exp=%0d", i, RegAddr, 10 + i); end
      if (RegData !== 32'hA0 + i) begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, RegData, 32'hA0 + i); end
      if (PC !== 32'h400 + i) begin bad++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, PC, 32'h400 + i); end
    end
    tick();
    total += 2;
    if (RegWrite !== 1'b0) begin bad++; $display("FAIL drain_done_we got=%b exp=0", RegWrite); end
    if (q_count !== 3'd0)  begin bad++; $display("FAIL drain_done_count got=%0d exp=0", q_count); end
  endtask

  task automatic test_zero_addr();
    wb_valid = 1'b1; wb_addr = '0; wb_data = 32'h55;
    md_valid = 1'b1; md_addr = '0; md_data = 32'h66;
    A1 = '0;
    #1;
    total += 2;
    if (md_ready !== 1'b1)  begin bad++; $display("FAIL zero_ready got=%b exp=1", md_ready); end
    if (pend_hit1 !== 1'b0) begin bad++; $display("FAIL zero_hit got=%b exp=0", pend_hit1); end
    tick();
    idle();
    total += 3;
    if (q_count !== 3'd0)  begin bad++; $display("FAIL zero_count got=%0d exp=0", q_count); end
    if (RegWrite !== 1'b0) begin bad++; $display("FAIL zero_we got=%b exp=0", RegWrite); end
    if (RegAddr !== 5'd13) begin bad++; $display("FAIL zero_hold_addr got=%0d exp=13", RegAddr); end
  endtask

  // Five pushes precede this, so the tail sits at slot 1 and slot 0 is hit by wrap.
  task automatic test_back_to_back();
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    for (int i = 0; i < 2; i++) begin
      md_valid = 1'b1; md_addr = 5'(16 + i); md_data = 32'hB0 + i; md_pc = 32'h500 + i;
      tick();
    end
    total += 1;
    if (q_count !== 3'd2) begin bad++; $display("FAIL b2b_pre_count got=%0d exp=2", q_count); end
    wb_valid = 1'b0; wb_addr = '0;
    for (int i = 0; i < 3; i++) begin
      md_valid = 1'b1; md_addr = 5'(18 + i); md_data = 32'hB2 + i; md_pc = 32'h502 + i;
      tick();
      total += 3;
      if (q_count !== 3'd2) begin bad++; $display("FAIL b2b_count[%0d] got=%0d exp=2", i, q_count); end
      if (RegAddr !== 5'(16 + i)) begin bad++; $display("FAIL b2b_addr[%0d] got=%0d exp=%0d", i, RegAddr, 16 + i); end
      if (RegData !== 32'hB0 + i) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, RegData, 32'hB0 + i); end
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      tick();
      total += 3;
      if (q_count !== 3'(1 - i)) begin bad++; $display("FAIL b2b_tail_count[%0d] got=%0d exp=%0d", i, q_count, 1 - i); end
      if (RegAddr !== 5'(19 + i)) begin bad++; $display("FAIL b2b_tail_addr[%0d] got=%0d exp=%0d", i, RegAddr, 19 + i); end
      if (PC !== 32'h503 + i) begin bad++; $display("FAIL b2b_tail_pc[%0d] got=%h exp=%h", i, PC, 32'h503 + i); end
    end
  endtask

  task automatic test_reset_mid();
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
    for (int i = 0; i < 3; i++) begin
      md_valid = 1'b1; md_addr = 5'(21 + i); md_data = 32'hC0 + i;
      tick();
    end
    total += 2;
    if (q_count !== 3'd3)  begin bad++; $display("FAIL mid_pre_count got=%0d exp=3", q_count); end
    if (RegWrite !== 1'b1) begin bad++; $display("FAIL mid_pre_we got=%b exp=1", RegWrite); end
    reset = 1'b0;
    #1;
    total += 3;
    if (q_count !== 3'd0)  begin bad++; $display("FAIL mid_count got=%0d exp=0", q_count); end
    if (RegWrite !== 1'b0) begin bad++; $display("FAIL mid_we got=%b exp=0", RegWrite); end
    if (RegAddr !== '0)    begin bad++; $display("FAIL mid_addr got=%0d exp=0", RegAddr); end
    idle();
    #2;
    reset = 1'b1;
    tick();
    total += 3;
    if (md_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", md_ready); end
    if (q_count !== 3'd0)  begin bad++; $display("FAIL mid_post_count got=%0d exp=0", q_count); end
    if (RegWrite !== 1'b0) begin bad++; $display("FAIL mid_post_we got=%b exp=0", RegWrite); end
  endtask

  initial begin
    test_reset();
    test_wb();
    test_md_single();
    test_fill();
    test_zero_addr();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer end of the general register file write port (RegWrite/RegAddr/RegData/PC).
- Merges two result producers onto that single port:
  - the in-order pipeline write-back stage, which has priority and no backpressure;
  - the long-latency multiply/divide result path, which is buffered in a small FIFO with a valid/ready handshake.
- Reports pending queued writes to decode so decode can stall RAW and WAW hazards.

Parameters:
- DEPTH, 4, number of md result queue entries (power of two, >=2).
- AW, 5, register address width.
- DW, 32, data and PC width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- wb_valid  input  1  pipeline write-back request this cycle; always accepted.
- wb_addr  input  AW  pipeline destination register.
- wb_data  input  DW  pipeline result.
- wb_pc  input  DW  PC of the pipeline instruction.
- md_valid  input  1  md result offered.
- md_ready  output  1  queue can accept; a transfer happens when md_valid && md_ready at the clock edge.
- md_addr  input  AW  md destination register.
- md_data  input  DW  md result.
- md_pc  input  DW  PC of the md instruction.
- A1  input  AW  decode read address 1.
- A2  input  AW  decode read address 2.
- pend_hit1  output  1  A1 matches a pending queued write.
- pend_hit2  output  1  A2 matches a pending queued write.
- RegWrite  output  1  GRF write enable (registered).
- RegAddr  output  AW  GRF write address (registered).
- RegData  output  DW  GRF write data (registered).
- PC  output  DW  PC of the committed write (registered).
- q_count  output  log2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (reset==0, asynchronous):
  - queue emptied; head/tail pointers = 0; q_count = 0;
  - RegWrite = 0, RegAddr = 0, RegData = 0, PC = 0.
  - Applies immediately mid-operation; queued results are lost.
- md_ready = (q_count != DEPTH), from registered state only; it is not combinationally dependent on a same-cycle pop.
- Enqueue on md_valid && md_ready:
  - md_addr != 0: {addr, data, pc} written at tail, tail advances.
  - md_addr == 0: handshake completes but nothing is stored (write to $0 discarded).
- Output select each rising edge, priority order:
  1. wb_valid && wb_addr != 0: output regs load wb_* and RegWrite = 1; queue is not popped.
  2. Else if queue non-empty: head entry loads the output regs with RegWrite = 1; head advances.
  3. Else: RegWrite = 0; RegAddr/RegData/PC hold their previous values.
- wb_valid with wb_addr == 0 counts as idle for arbitration, so the queue may pop that cycle.
- Latency:
  - pipeline write appears on the GRF port 1 cycle after wb_valid;
  - md result appears no earlier than 2 cycles after its handshake, since there is no bypass around the queue.
- Simultaneous enqueue and pop in one cycle: q_count unchanged; pointers both advance and wrap modulo DEPTH.
- Ordering: queue strictly FIFO. WAW and RAW correctness relies on decode stalling on pend_hit.
- pend_hitN = (AN != 0) && (AN matches any valid queue entry, OR (md_valid && md_ready && md_addr == AN)).
  - The output register is excluded, because the GRF forwards RegData internally.
- Starvation: the queue drains only in cycles without a nonzero-address wb write. This is accepted because pipeline stalls on pend_hit create drain slots.

Test Plan:
- Reset pulse low mid-stream with 3 entries queued -> q_count = 0, RegWrite = 0 immediately, md_ready = 1 after release.
- wb_valid = 1, wb_addr = 5, wb_data = 0x1234 -> next cycle RegWrite = 1, RegAddr = 5, RegData = 0x1234, PC = wb_pc.
- md result (addr 8, 0xDEAD) handshake on an idle pipeline -> q_count = 1 and pend_hit1 = 1 for A1 = 8; two edges later RegAddr = 8, RegData = 0xDEAD, q_count = 0.
- Fill DEPTH = 4 md entries while wb_valid is held with nonzero addresses -> md_ready = 0 at count 4; release wb -> entries commit in FIFO order on 4 consecutive cycles.
- md_addr = 0 and wb_addr = 0 requests -> md handshake completes, q_count unchanged, RegWrite stays 0.
- Simultaneous push and pop at count 2 with pointer wrap (after 6 total transfers) -> count stays 2 and data order is preserved.
